// File: rtl/hazard_unit_mc.sv
// Multi-channel stall/flush arbiter for the pipelined RISC-V core.
// Optional watchdog: define HAZARD_UNIT_MC_WATCHDOG_EN.
package riscv_pkg;
   typedef enum logic [1:0] {
      ENABLE = 2'd0,
      STALL  = 2'd1,
      FLUSH  = 2'd2
   } HAZARD_ctrl;
endpackage

module hazard_unit_mc
   import riscv_pkg::*;
#(
   parameter int NMEM       = 2,
   parameter int NSTAGE     = 5,
   parameter int BR_PENALTY = 1,
   parameter int RA_W       = 5,
   parameter int TIMEOUT    = 255
) (
   input  logic                     CLK,
   input  logic                     RSTn,
   input  logic                     EN,
   input  logic                     BRANCH_taken_in,
   input  logic [NMEM-1:0]          MEM_busy_in,
   input  logic                     LOAD_in,
   input  logic [RA_W-1:0]          EX_MEM_RD_in,
   input  logic [RA_W-1:0]          DEC_EX_RS1_in,
   input  logic [RA_W-1:0]          DEC_EX_RS2_in,
   input  logic [1:0]               RS_used_in,
   output logic [NMEM-1:0]          MEM_req_out,
   output HAZARD_ctrl [NSTAGE-1:0]  STAGE_ctrl_out,
   output logic                     TIMEOUT_err_out
);

   typedef HAZARD_ctrl [NSTAGE-1:0] ctrl_t;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      BR_FLUSH = 2'd2
   } state_t;

   localparam int S_PC  = 0;
   localparam int S_IFD = 1;
   localparam int S_DEX = 2;

   state_t     r_state;
   logic [2:0] r_fcnt;
   logic       w_busy;
   logic       w_lu;
   logic       w_rs1_hit;
   logic       w_rs2_hit;
   ctrl_t      w_ctrl;
   logic [NMEM-1:0] w_req;

   function automatic ctrl_t fill(HAZARD_ctrl v);
      ctrl_t c;
      for (int i = 0; i < NSTAGE; i++)
         c[i] = v;
      return c;
   endfunction

   assign w_busy    = |MEM_busy_in;
   assign w_rs1_hit = RS_used_in[0] && (EX_MEM_RD_in == DEC_EX_RS1_in);
   assign w_rs2_hit = RS_used_in[1] && (EX_MEM_RD_in == DEC_EX_RS2_in);
   assign w_lu      = LOAD_in && (EX_MEM_RD_in != '0)
                      && (w_rs1_hit || w_rs2_hit);

   always_comb begin
      w_ctrl = fill(ENABLE);
      w_req  = '1;
      if (!RSTn) begin
         w_ctrl = fill(FLUSH);
         w_req  = '0;
      end else if (!EN) begin
         w_ctrl = fill(STALL);
         w_req  = '0;
      end else begin
         unique case (r_state)
            RUN: begin
               if (w_busy) begin
                  w_ctrl = fill(STALL);
               end else if (w_lu) begin
                  w_ctrl[S_PC]  = STALL;
                  w_ctrl[S_IFD] = STALL;
                  w_ctrl[S_DEX] = FLUSH;
               end else if (BRANCH_taken_in) begin
                  w_ctrl[S_PC]  = STALL;
                  w_ctrl[S_IFD] = FLUSH;
               end
            end
            MEM_WAIT: begin
               if (w_busy) begin
                  w_ctrl = fill(STALL);
                  w_req  = '0;
               end
            end
            BR_FLUSH: begin
               if (w_busy)
                  w_ctrl = fill(STALL);
               else
                  w_ctrl[S_IFD] = FLUSH;
            end
            default: begin
               w_ctrl = fill(STALL);
               w_req  = '0;
            end
         endcase
      end
   end

   assign STAGE_ctrl_out = w_ctrl;
   assign MEM_req_out    = w_req;

   // Branch loses to load-use: its producer is held and re-presents it.
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         r_state <= RUN;
         r_fcnt  <= 3'd0;
      end else if (EN) begin
         unique case (r_state)
            RUN: begin
               if (w_busy) begin
                  r_state <= MEM_WAIT;
               end else if (!w_lu && BRANCH_taken_in
                            && BR_PENALTY > 1) begin
                  r_fcnt  <= 3'(BR_PENALTY - 1);
                  r_state <= BR_FLUSH;
               end
            end
            MEM_WAIT: begin
               if (!w_busy)
                  r_state <= (r_fcnt != 3'd0) ? BR_FLUSH : RUN;
            end
            BR_FLUSH: begin
               if (w_busy) begin
                  r_state <= MEM_WAIT;
               end else begin
                  r_fcnt <= (r_fcnt == 3'd0) ? 3'd0 : r_fcnt - 3'd1;
                  if (r_fcnt <= 3'd1)
                     r_state <= RUN;
               end
            end
            default: r_state <= RUN;
         endcase
      end
   end

`ifdef HAZARD_UNIT_MC_WATCHDOG_EN
   logic [15:0] r_wcnt;
   logic [15:0] w_wcnt_nxt;
   logic        r_err;
   logic        w_wait;

   assign w_wait     = (r_state == MEM_WAIT) && w_busy;
   assign w_wcnt_nxt = !w_wait ? 16'd0 :
                       (r_wcnt >= 16'(TIMEOUT)) ? r_wcnt :
                       r_wcnt + 16'd1;

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         r_wcnt <= 16'd0;
         r_err  <= 1'b0;
      end else if (EN) begin
         r_wcnt <= w_wcnt_nxt;
         if (w_wcnt_nxt == 16'(TIMEOUT))
            r_err <= 1'b1;
      end
   end

   assign TIMEOUT_err_out = r_err;
`else
   assign TIMEOUT_err_out = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Scoreboard bench for hazard_unit_mc (NMEM=3, NSTAGE=6, BR_PENALTY=3).
// Expected values are pushed per cycle and popped on the falling edge.
module tb_hazard_unit_mc;
   import riscv_pkg::*;

`ifdef HAZARD_UNIT_MC_WATCHDOG_EN
   localparam bit WD = 1'b1;
`else
   localparam bit WD = 1'b0;
`endif

   localparam logic [1:0] E = ENABLE;
   localparam logic [1:0] S = STALL;
   localparam logic [1:0] F = FLUSH;

   logic CLK = 1'b0;
   logic RSTn = 1'b0;
   logic EN = 1'b1;
   logic br = 1'b0;
   logic [2:0] busy = 3'd0;
   logic ld = 1'b0;
   logic [4:0] rd = 5'd0;
   logic [4:0] rs1 = 5'd0;
   logic [4:0] rs2 = 5'd0;
   logic [1:0] used = 2'd0;
   logic [2:0] req;
   HAZARD_ctrl [5:0] ctrl;
   logic [11:0] obs_ctrl;
   logic err;

   typedef struct {
      string       tag;
      logic [11:0] ctrl;
      logic [2:0]  req;
      logic        err;
   } exp_t;

   exp_t q[$];
   int n_chk = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   hazard_unit_mc #(
      .NMEM(3), .NSTAGE(6), .BR_PENALTY(3),
      .RA_W(5), .TIMEOUT(4)
   ) dut (
      .CLK(CLK),
      .RSTn(RSTn),
      .EN(EN),
      .BRANCH_taken_in(br),
      .MEM_busy_in(busy),
      .LOAD_in(ld),
      .EX_MEM_RD_in(rd),
      .DEC_EX_RS1_in(rs1),
      .DEC_EX_RS2_in(rs2),
      .RS_used_in(used),
      .MEM_req_out(req),
      .STAGE_ctrl_out(ctrl),
      .TIMEOUT_err_out(err)
   );

   assign obs_ctrl = ctrl;

   function automatic logic [11:0] pv(
      logic [1:0] pc, logic [1:0] ifd, logic [1:0] dex,
      logic [1:0] mid, logic [1:0] wb);
      return {wb, mid, mid, dex, ifd, pc};
   endfunction

   task automatic chk(string tag, logic [31:0] o, logic [31:0] x);
      n_chk++;
      if (o !== x) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, o, x);
      end
   endtask

   task automatic cyc(
      string tag, logic r, logic en, logic b, logic [2:0] bz,
      logic l, logic [4:0] d, logic [4:0] s1, logic [4:0] s2,
      logic [1:0] u, logic [11:0] ec, logic [2:0] er, logic ee);
      exp_t x;
      @(posedge CLK);
      #1;
      RSTn = r; EN = en; br = b; busy = bz;
      ld = l; rd = d; rs1 = s1; rs2 = s2; used = u;
      x.tag = tag; x.ctrl = ec; x.req = er; x.err = ee & WD;
      q.push_back(x);
   endtask

   always @(negedge CLK) begin : mon
      exp_t x;
      if (q.size() != 0) begin
         x = q.pop_front();
         chk({x.tag, "/ctrl"}, 32'(obs_ctrl), 32'(x.ctrl));
         chk({x.tag, "/req"}, 32'(req), 32'(x.req));
         chk({x.tag, "/err"}, 32'(err), 32'(x.err));
      end
   end

   initial begin
      logic [11:0] AE, AS, AF, LU, B0, BF;
      AE = pv(E, E, E, E, E);
      AS = pv(S, S, S, S, S);
      AF = pv(F, F, F, F, F);
      LU = pv(S, S, F, E, E);
      B0 = pv(S, F, E, E, E);
      BF = pv(E, F, E, E, E);

      cyc("rst",  0,1,0,0, 0,0,0,0,0, AF,0,0);
      cyc("idle", 1,1,0,0, 0,0,0,0,0, AE,7,0);
      // load-use qualification
      cyc("lu1",  1,1,0,0, 1,5,5,0,2'b01, LU,7,0);
      cyc("lu2",  1,1,0,0, 1,7,3,7,2'b10, LU,7,0);
      cyc("lux0", 1,1,0,0, 1,0,0,0,2'b01, AE,7,0);
      cyc("lunu", 1,1,0,0, 1,5,5,0,2'b00, AE,7,0);
      cyc("lurs", 1,1,0,0, 1,5,3,5,2'b01, AE,7,0);
      cyc("nold", 1,1,0,0, 0,5,5,5,2'b11, AE,7,0);
      // branch penalty 3
      cyc("br0",  1,1,1,0, 0,0,0,0,0, B0,7,0);
      cyc("br1",  1,1,0,0, 0,0,0,0,0, BF,7,0);
      cyc("br2",  1,1,0,0, 0,0,0,0,0, BF,7,0);
      cyc("br3",  1,1,0,0, 0,0,0,0,0, AE,7,0);
      // channel 2 busy for 4 cycles
      cyc("mw0",  1,1,0,4, 0,0,0,0,0, AS,7,0);
      cyc("mw1",  1,1,0,4, 0,0,0,0,0, AS,0,0);
      cyc("mw2",  1,1,0,4, 0,0,0,0,0, AS,0,0);
      cyc("mw3",  1,1,0,4, 0,0,0,0,0, AS,0,0);
      cyc("mwe",  1,1,0,0, 0,0,0,0,0, AE,7,0);
      cyc("mwr",  1,1,0,0, 0,0,0,0,0, AE,7,0);
      cyc("ib0",  1,1,0,1, 0,0,0,0,0, AS,7,0);
      cyc("ibe",  1,1,0,0, 0,0,0,0,0, AE,7,0);
      // busy in BR_FLUSH at fcnt=1; branch ignored there
      cyc("bb0",  1,1,1,0, 0,0,0,0,0, B0,7,0);
      cyc("bbf",  1,1,1,0, 0,0,0,0,0, BF,7,0);
      cyc("bbw0", 1,1,0,2, 0,0,0,0,0, AS,7,0);
      cyc("bbw1", 1,1,0,2, 0,0,0,0,0, AS,0,0);
      cyc("bbe",  1,1,0,0, 0,0,0,0,0, AE,7,0);
      cyc("bbl",  1,1,0,0, 0,0,0,0,0, BF,7,0);
      cyc("bbr",  1,1,0,0, 0,0,0,0,0, AE,7,0);
      // load-use beats branch; branch re-presented
      cyc("lub",  1,1,1,0, 1,5,5,0,2'b01, LU,7,0);
      cyc("lub0", 1,1,1,0, 0,0,0,0,0, B0,7,0);
      cyc("lub1", 1,1,0,0, 0,0,0,0,0, BF,7,0);
      cyc("lub2", 1,1,0,0, 0,0,0,0,0, BF,7,0);
      cyc("lubr", 1,1,0,0, 0,0,0,0,0, AE,7,0);
      // busy + lu + branch together
      cyc("a3",   1,1,1,2, 1,5,5,0,2'b01, AS,7,0);
      cyc("a3w",  1,1,0,2, 0,0,0,0,0, AS,0,0);
      cyc("a3e",  1,1,0,0, 0,0,0,0,0, AE,7,0);
      cyc("a3r",  1,1,0,0, 0,0,0,0,0, AE,7,0);
      // EN low mid-flush holds fcnt
      cyc("en0",  1,1,1,0, 0,0,0,0,0, B0,7,0);
      cyc("enf",  1,1,0,0, 0,0,0,0,0, BF,7,0);
      cyc("enx0", 1,0,0,0, 0,0,0,0,0, AS,0,0);
      cyc("enx1", 1,0,1,1, 0,0,0,0,0, AS,0,0);
      cyc("enl",  1,1,0,0, 0,0,0,0,0, BF,7,0);
      cyc("enr",  1,1,0,0, 0,0,0,0,0, AE,7,0);
      // watchdog, TIMEOUT=4, busy for 10 cycles
      cyc("wd0",  1,1,0,4, 0,0,0,0,0, AS,7,0);
      for (int i = 1; i < 10; i++)
         cyc($sformatf("wd%0d", i), 1,1,0,4, 0,0,0,0,0,
             AS,0,(i >= 5));
      cyc("wde",  1,1,0,0, 0,0,0,0,0, AE,7,1);
      cyc("wdh",  1,1,0,0, 0,0,0,0,0, AE,7,1);
      cyc("wdrs", 0,1,0,0, 0,0,0,0,0, AF,0,1);
      cyc("wdc",  1,1,0,0, 0,0,0,0,0, AE,7,0);
      cyc("wdb0", 1,1,1,0, 0,0,0,0,0, B0,7,0);
      cyc("wdb1", 1,1,0,0, 0,0,0,0,0, BF,7,0);
      cyc("wdb2", 1,1,0,0, 0,0,0,0,0, BF,7,0);
      cyc("wdb3", 1,1,0,0, 0,0,0,0,0, AE,7,0);

      @(negedge CLK);
      #1;
      if (q.size() != 0) begin
         n_chk++;
         n_err++;
         $display("FAIL drain: got %0d left want 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
